// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader_if
//  Description : Signal bundle between the UART-fed instruction loader and
//                its environment (UART RX, debug unit, fetch-stage memory).
//                  i_start                 - load session start pulse
//                  i_rx_data / i_rx_done   - received byte and its strobe
//                  o_instrucction_address  - byte address of written word
//                  o_instruction           - assembled instruction word
//                  o_flag_write_intruc     - memory write enable
//                  o_busy / o_done / o_error, o_word_count - session status
//                master : loader side (drives the o_* signals)
//                slave  : environment side (drives the i_* signals)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_loader_if #(
  parameter int unsigned BITS_SIZE  = 32,
  parameter int unsigned SIZE_TOTAL = 256
);
  localparam int unsigned c_CNT_W = $clog2(SIZE_TOTAL / 4) + 1;

  logic                 i_start;
  logic [7:0]           i_rx_data;
  logic                 i_rx_done;
  logic [BITS_SIZE-1:0] o_instrucction_address;
  logic [BITS_SIZE-1:0] o_instruction;
  logic                 o_flag_write_intruc;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;
  logic [c_CNT_W-1:0]   o_word_count;

  modport master (
    input  i_start, i_rx_data, i_rx_done,
    output o_instrucction_address, o_instruction, o_flag_write_intruc,
           o_busy, o_done, o_error, o_word_count
  );

  modport slave (
    output i_start, i_rx_data, i_rx_done,
    input  o_instrucction_address, o_instruction, o_flag_write_intruc,
           o_busy, o_done, o_error, o_word_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Assembles the UART byte stream (big-endian, first byte is
//                the MSB) into instruction words and writes them one per
//                cycle into the fetch-stage program memory. The session ends
//                in DONE after the halt word is written, or in ERROR when the
//                last memory slot is written without seeing the halt word.
//  Ports       : i_clk   - system clock, rising edge
//                i_reset - asynchronous active-high reset
//                bus     - instr_loader_if.master (start, RX byte stream,
//                          memory write port and session status)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int unsigned          BITS_SIZE  = 32,
  parameter int unsigned          SIZE_TOTAL = 256,
  parameter logic [BITS_SIZE-1:0] HALT_WORD  = {BITS_SIZE{1'b1}}
) (
  input  wire logic       i_clk,
  input  wire logic       i_reset,
  instr_loader_if.master  bus
);

  localparam int unsigned          c_CNT_W     = $clog2(SIZE_TOTAL / 4) + 1;
  localparam logic [BITS_SIZE-1:0] c_LAST_ADDR = BITS_SIZE'(SIZE_TOTAL - 4);
  localparam logic [BITS_SIZE-1:0] c_ADDR_STEP = BITS_SIZE'(4);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_RECV  = 3'd1;
  localparam logic [2:0] c_S_WRITE = 3'd2;
  localparam logic [2:0] c_S_DONE  = 3'd3;
  localparam logic [2:0] c_S_ERROR = 3'd4;

  logic [2:0]           r_state;
  logic [1:0]           r_byte_cnt;
  // Only the three most recent bytes need storing: the fourth byte is
  // appended combinationally when the word completes.
  logic [BITS_SIZE-9:0] r_bytes;
  logic [BITS_SIZE-1:0] r_addr;      // slot the next completed word goes to
  logic [BITS_SIZE-1:0] r_addr_out;  // address presented on the write port
  logic [BITS_SIZE-1:0] r_instr;     // word presented on the write port
  logic [c_CNT_W-1:0]   r_word_count;

  logic [BITS_SIZE-1:0] w_shift_next;
  logic                 w_is_halt;
  logic                 w_last_slot;

  assign w_shift_next = {r_bytes, bus.i_rx_data};
  assign w_is_halt    = (r_instr == HALT_WORD);
  assign w_last_slot  = (r_addr == c_LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= c_S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_bytes      <= '0;
      r_addr       <= '0;
      r_addr_out   <= '0;
      r_instr      <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        // Start is honoured from every resting state; bytes are ignored.
        c_S_IDLE, c_S_DONE, c_S_ERROR: begin
          if (bus.i_start) begin
            r_state      <= c_S_RECV;
            r_byte_cnt   <= 2'd0;
            r_bytes      <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
          end
        end

        c_S_RECV: begin
          if (bus.i_rx_done) begin
            r_bytes <= w_shift_next[BITS_SIZE-9:0];
            if (r_byte_cnt == 2'd3) begin
              // Latch the port values here so they stay stable through the
              // write cycle and hold afterwards, even while the next word is
              // already being shifted in.
              r_byte_cnt <= 2'd0;
              r_instr    <= w_shift_next;
              r_addr_out <= r_addr;
              r_state    <= c_S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        c_S_WRITE: begin
          r_word_count <= r_word_count + c_CNT_W'(1);
          if (w_is_halt) begin
            r_state <= c_S_DONE;
          end else if (w_last_slot) begin
            r_state <= c_S_ERROR;
          end else begin
            r_addr  <= r_addr + c_ADDR_STEP;
            r_state <= c_S_RECV;
            // A byte landing in the write cycle is the first byte of the
            // next word; it is dropped when the session is ending.
            if (bus.i_rx_done) begin
              r_bytes    <= w_shift_next[BITS_SIZE-9:0];
              r_byte_cnt <= 2'd1;
            end
          end
        end

        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // Status and write enable decode straight from the state register so they
  // follow an asynchronous reset immediately.
  assign bus.o_flag_write_intruc    = (r_state == c_S_WRITE);
  assign bus.o_busy                 = (r_state == c_S_RECV) || (r_state == c_S_WRITE);
  assign bus.o_done                 = (r_state == c_S_DONE);
  assign bus.o_error                = (r_state == c_S_ERROR);
  assign bus.o_instrucction_address = r_addr_out;
  assign bus.o_instruction          = r_instr;
  assign bus.o_word_count           = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader. A cycle-level
//                reference model built on a byte queue predicts every
//                output each cycle; directed scenarios additionally check
//                a log of observed memory writes against fixed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

  localparam int unsigned BITS_SIZE  = 32;
  localparam int unsigned SIZE_TOTAL = 256;
  localparam logic [31:0] HALT       = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_loader_if #(.BITS_SIZE(BITS_SIZE), .SIZE_TOTAL(SIZE_TOTAL)) bus ();

  instr_loader #(
    .BITS_SIZE (BITS_SIZE),
    .SIZE_TOTAL(SIZE_TOTAL),
    .HALT_WORD (HALT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_active;    // session collecting bytes
  bit           m_pending;   // a completed word is on the write port
  bit           m_done;
  bit           m_error;
  int           m_addr;
  int           m_count;
  logic [31:0]  m_last_addr;
  logic [31:0]  m_last_word;
  byte unsigned m_bytes[$];

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_done = 0; m_error = 0;
    m_addr = 0; m_count = 0; m_last_addr = '0; m_last_word = '0;
    m_bytes.delete();
  endtask

  task automatic model_step();
    if (rst) return;
    if (m_pending) begin
      m_pending = 0;
      m_count++;
      if (m_last_word == HALT) m_done = 1;
      else if (m_addr == SIZE_TOTAL - 4) m_error = 1;
      else m_addr += 4;
      m_active = !(m_done || m_error);
      if (m_active && bus.i_rx_done) m_bytes.push_back(bus.i_rx_data);
    end else if (m_active) begin
      if (bus.i_rx_done) begin
        m_bytes.push_back(bus.i_rx_data);
        if (m_bytes.size() == 4) begin
          m_last_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_last_addr = 32'(m_addr);
          m_pending   = 1;
          m_bytes.delete();
        end
      end
    end else if (bus.i_start) begin
      m_active = 1; m_done = 0; m_error = 0; m_count = 0; m_addr = 0;
      m_bytes.delete();
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle comparison and write log ----------------
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log[$];

  task automatic cycle_check();
    check("wr_en",  32'(bus.o_flag_write_intruc), 32'(m_pending));
    check("addr",   bus.o_instrucction_address, m_last_addr);
    check("instr",  bus.o_instruction, m_last_word);
    check("busy",   32'(bus.o_busy), 32'(m_active));
    check("done",   32'(bus.o_done), 32'(m_done));
    check("error",  32'(bus.o_error), 32'(m_error));
    check("wcount", 32'(bus.o_word_count), 32'(m_count));
    if (bus.o_flag_write_intruc === 1'b1)
      wr_log.push_back({bus.o_instrucction_address, bus.o_instruction});
  endtask

  always @(negedge clk) cycle_check();

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    idle(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[31-8*i -: 8], int'($urandom_range(maxgap, 0)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e = (idx < wr_log.size()) ? wr_log[idx] : '0;
    check({tag, "_a"}, e.a, a);
    check({tag, "_d"}, e.d, d);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.i_start   = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    rst = 1'b1;
    model_reset();
    idle(2);
    rst = 1'b0;
    check("rst_count", 32'(bus.o_word_count), 32'd0);
    check("rst_instr", bus.o_instruction, 32'd0);

    // 1: simple program terminated by halt
    wr_log.delete();
    start_pulse();
    send_word(32'h2008_0005, 1);
    send_word(HALT, 1);
    idle(3);
    check("t1_nwr", 32'(wr_log.size()), 32'd2);
    check_log("t1_w0", 0, 32'h0, 32'h2008_0005);
    check_log("t1_w1", 1, 32'h4, HALT);
    check("t1_done", 32'(bus.o_done), 32'd1);
    check("t1_err", 32'(bus.o_error), 32'd0);
    check("t1_cnt", 32'(bus.o_word_count), 32'd2);

    // 2: endianness and one-cycle write latency
    wr_log.delete();
    start_pulse();
    send_byte(8'hAA, 0); send_byte(8'hBB, 2); send_byte(8'hCC, 0);
    bus.i_rx_data = 8'hDD; bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    check("t2_wr_on", 32'(bus.o_flag_write_intruc), 32'd1);
    check("t2_instr", bus.o_instruction, 32'hAABB_CCDD);
    tick();
    check("t2_wr_off", 32'(bus.o_flag_write_intruc), 32'd0);
    send_word(HALT, 0);
    idle(2);
    check("t2_nwr", 32'(wr_log.size()), 32'd2);

    // 3: overflow without halt
    wr_log.delete();
    start_pulse();
    for (int i = 0; i < SIZE_TOTAL / 4; i++) send_word(32'h0, 1);
    idle(3);
    check("t3_nwr", 32'(wr_log.size()), 32'd64);
    check_log("t3_first", 0, 32'h0, 32'h0);
    check_log("t3_last", 63, 32'hFC, 32'h0);
    check("t3_err", 32'(bus.o_error), 32'd1);
    check("t3_done", 32'(bus.o_done), 32'd0);
    check("t3_cnt", 32'(bus.o_word_count), 32'd64);
    send_word(32'h1234_5678, 0);
    idle(3);
    check("t3_nwr_after", 32'(wr_log.size()), 32'd64);

    // 4: strobe held for 8 cycles, 5th byte lands in the write cycle
    wr_log.delete();
    start_pulse();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
    send_word(HALT, 0);
    idle(2);
    check_log("t4_w0", 0, 32'h0, 32'h0102_0304);
    check_log("t4_w1", 1, 32'h4, 32'h0506_0708);
    check("t4_cnt", 32'(bus.o_word_count), 32'd3);

    // 5: reset mid-word
    wr_log.delete();
    start_pulse();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    do_reset();
    check("t5_nwr", 32'(wr_log.size()), 32'd0);
    check("t5_busy", 32'(bus.o_busy), 32'd0);
    start_pulse();
    send_word(HALT, 1);
    idle(2);
    check_log("t5_w0", 0, 32'h0, HALT);

    // 6: ignored bytes in IDLE, ignored start in RECV, restart from DONE
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    check("t6_idle_nwr", 32'(wr_log.size()), 32'd0);
    start_pulse();
    send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    start_pulse();
    send_byte(8'hBE, 0); send_byte(8'hEF, 1);
    check_log("t6_w0", 0, 32'h0, 32'hDEAD_BEEF);
    send_word(HALT, 0);
    idle(2);
    check("t6_done", 32'(bus.o_done), 32'd1);
    start_pulse();
    check("t6_done_clr", 32'(bus.o_done), 32'd0);
    check("t6_cnt_clr", 32'(bus.o_word_count), 32'd0);
    wr_log.delete();
    send_word(HALT, 0);
    idle(2);
    check_log("t6_restart", 0, 32'h0, HALT);

    // randomized sessions, checked cycle by cycle against the model
    for (int s = 0; s < 40; s++) begin
      int nw;
      if ($urandom_range(9, 0) == 0) do_reset();
      start_pulse();
      nw = int'($urandom_range(12, 0));
      for (int w = 0; w < nw && m_active; w++) begin
        logic [31:0] word;
        word = ($urandom_range(15, 0) == 0) ? HALT : $urandom;
        if ($urandom_range(7, 0) == 0) start_pulse();
        send_word(word, 3);
        if ($urandom_range(11, 0) == 0) begin
          send_byte(8'($urandom), 0);
          do_reset();
        end
      end
      if (m_active) send_word(HALT, 2);
      idle(2);
      send_byte(8'($urandom), int'($urandom_range(2, 0)));
      idle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream feeder of the instruction-fetch stage's program memory.
- Assembles the UART receiver's byte stream into 32-bit instruction words and drives the memory write port (address, instruction, write flag) in the same cycle-by-cycle form the fetch stage consumes.
- Loading ends when the halt word has been written, or with an error if memory fills first.
- Sits between the UART RX block and the fetch stage, under control of the debug unit.

Parameters:
- BITS_SIZE, 32: instruction/address width.
- SIZE_TOTAL, 256: instruction memory size in bytes (64 word slots).
- HALT_WORD, 32'hFFFFFFFF: terminating instruction; it is itself written to memory.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  one-cycle pulse that begins a load session.
- i_rx_data  input  8  received byte; valid only while i_rx_done=1.
- i_rx_done  input  1  one-cycle strobe: i_rx_data holds a new byte.
- o_instrucction_address  output  BITS_SIZE  byte address of the word being written.
- o_instruction  output  BITS_SIZE  assembled instruction word.
- o_flag_write_intruc  output  1  memory write enable, one cycle per word.
- o_busy  output  1  high in RECV and WRITE states.
- o_done  output  1  halt word written; held until the next i_start or reset.
- o_error  output  1  memory filled without a halt word; held until the next i_start or reset.
- o_word_count  output  $clog2(SIZE_TOTAL/4)+1  number of words written this session, including the halt word.

Behaviour:
- Reset (asynchronous) values:
  - State goes to IDLE.
  - All outputs are 0, including address, instruction and o_word_count.
  - Byte counter and word shift register are 0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_rx_done is ignored.
  - i_start moves to RECV, clearing the byte counter, address, word count, o_done and o_error.
- RECV, on each i_rx_done:
  - Shift register takes {shreg[23:0], i_rx_data}, so the first byte received is the MSB (big-endian).
  - Byte counter increments.
  - On the 4th byte, the byte counter wraps to 0 and the state goes to WRITE on the next edge.
- WRITE (exactly one cycle):
  - o_flag_write_intruc=1, o_instruction=shreg, o_instrucction_address=current address.
  - Write latency is exactly 1 cycle after the clock edge that samples the 4th i_rx_done.
  - o_word_count increments on exit from WRITE.
- Exits from WRITE:
  - If the word equals HALT_WORD, go to DONE.
  - Otherwise, if current address == SIZE_TOTAL-4 (last slot just written), go to ERROR.
  - Otherwise, address += 4 and go to RECV.
- Byte arriving during WRITE:
  - An i_rx_done in WRITE is captured as byte 0 of the next word: the byte counter becomes 1.
  - That byte is discarded if the next state is DONE or ERROR.
- o_flag_write_intruc is 0 in every state except WRITE.
- Address and instruction outputs hold their last values outside WRITE.
- DONE: o_done=1. ERROR: o_error=1.
  - Both are absorbing until i_start (which restarts exactly as from IDLE) or reset.
  - i_rx_done is ignored in both.
- i_start in RECV or WRITE is ignored; a session is not restarted mid-word.
- Address arithmetic is BITS_SIZE wide, is always a multiple of 4, and never exceeds SIZE_TOTAL-4.
- Reset asserted mid-session:
  - Aborts immediately; any partial word is lost.
  - If the abort happens during WRITE, o_flag_write_intruc drops asynchronously.
- Back-to-back i_rx_done on consecutive cycles must be accepted without loss, including across the WRITE cycle.

Test Plan:
1. Reset, i_start, then bytes 20 08 00 05, FF FF FF FF:
   - Write pulse at addr 0x0 with 0x20080005, then at addr 0x4 with 0xFFFFFFFF.
   - o_done=1, o_word_count=2, o_error=0.
2. Endianness and latency: bytes AA BB CC DD:
   - o_instruction=0xAABBCCDD.
   - o_flag_write_intruc high exactly one cycle, on the cycle after the 4th i_rx_done.
3. Overflow: 64 non-halt words (e.g. 0x00000000):
   - 64 writes at addresses 0x0..0xFC.
   - o_error=1 after the last write, o_done=0, o_word_count=64.
   - A further byte produces no write.
4. Back-to-back strobe: i_rx_done held high 8 consecutive cycles with bytes 01..08:
   - Writes 0x01020304 at 0x0 and 0x05060708 at 0x4.
   - No byte lost; the 5th byte arrives during the WRITE cycle.
5. Reset mid-word:
   - 2 bytes, then i_reset pulse: outputs return to 0, state IDLE, no write pulse.
   - New i_start followed by a halt word writes 0xFFFFFFFF at address 0.
6. Ignored inputs and restart:
   - i_rx_done in IDLE causes no write.
   - i_start in RECV does not reset the byte counter.
   - i_start in DONE clears o_done and o_word_count and restarts at address 0.
